mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master arbiter that shares the single data-memory/peripheral port (RAM at 0x00000000–0x000007FF, timer and digit registers at 0x4000_00xx) between the CPU data port (master 0) and the UART loader/debug engine (master 1). It sits between both masters and the memory block. A registered grant FSM performs exactly one access per grant, with optional burst lock. Master 0 has fixed priority, and a compile-time starvation guard protects master 1.

## Interface
- STARVE_LIMIT, 4: consecutive master-0 acks, while master 1 waits, that force a master-1 grant (guard build only); legal 1–255.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- m0_req, m1_req  in  1  access request; held high until the matching ack.
- m0_we, m1_we  in  1  1 = write, 0 = read; held stable with req.
- m0_addr, m1_addr  in  32  byte address; held stable with req.
- m0_wdata, m1_wdata  in  32  write data; held stable with req.
- m0_lock, m1_lock  in  1  keep the grant after this access.
- m0_gnt, m1_gnt  out  1  registered grant; at most one high.
- m0_ack, m1_ack  out  1  access performed this cycle; read data valid this cycle.
- m0_rdata, m1_rdata  out  32  mem_rdata when the own ack is high, else 0.
- mem_addr  out  32  to memory Address.
- mem_wdata  out  32  to memory Write_data.
- mem_rd  out  1  to memory MemRead.
- mem_wr  out  1  to memory MemWrite.
- mem_rdata  in  32  from memory Read_data; combinational in the same cycle.
- busy  out  1  high when state ≠ IDLE.

## Operation
- States: IDLE, G0, G1. Reset → IDLE, starve_cnt = 0.
- IDLE transitions:
  - m1_req and starve_cnt == STARVE_LIMIT (guard build) → G1.
  - Else m0_req → G0.
  - Else m1_req → G1.
  - Else stay in IDLE.
- Gx (x = granted master):
  - mx_gnt = 1.
  - mem_addr/mem_wdata driven from mx; other master ignored.
  - mem_rd = mx_req & ~mx_we; mem_wr = mx_req & mx_we; mx_ack = mx_req.
- Leaving Gx:
  - mx_ack & mx_lock, not forced off → stay in Gx.
  - Otherwise → IDLE.
  - ~mx_req in Gx (requester withdrew) → IDLE, no access, no ack.
- Starvation counter (guard build, 8 bits):
  - +1 on each m0_ack with m1_req high; saturates at STARVE_LIMIT.
  - Cleared on entering G1.
  - Cleared on any IDLE cycle with m1_req low.
- Forced release: in G0, an m0_ack that brings starve_cnt to STARVE_LIMIT forces G0 → IDLE regardless of m0_lock.
- Idle/unused outputs:
  - In IDLE: mem_addr = 0, mem_wdata = 0, mem_rd = 0, mem_wr = 0, all acks 0.
  - The non-granted master's gnt, ack and rdata are 0.
- mem_wr and mem_rd are gated by ~reset, so no memory access occurs in a reset cycle.

## Timing
- Reset values: all gnt, ack, mem_rd, mem_wr = 0; mem_addr, mem_wdata, both rdata = 0; busy = 0.
- Single access:
  - req rises in cycle N (IDLE).
  - gnt high in N+1; ack and access in N+1; write commits at the end of N+1.
  - Master drops req in N+2.
  - Arbiter is in IDLE in N+2; next grant no earlier than N+3.
- Locked burst: one access per cycle. Each cycle presents new addr/we/wdata, still with req high.
- Simultaneous m0_req and m1_req in IDLE: master 0 wins unless the starve threshold has been reached.
- Reset asserted mid-G0/G1: next state IDLE. The access in that cycle is suppressed and no ack is returned, so the master must re-request.
- Reading 0x4000_0004 (TL) returns the live timer value of the same cycle; the arbiter adds no read latency.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - starve_cnt, the forced master-1 grant and the forced lock release are present.
- Not defined:
  - Strict master-0 priority; m0_lock is honoured indefinitely.
  - No counter logic is synthesized; STARVE_LIMIT is unused.

## Test plan
- Reset: after reset, all outputs are 0 and busy = 0. m0 writes 0xDEADBEEF to 0x00000004; a later m0 read of 0x00000004 returns 0xDEADBEEF with m0_ack one cycle after req.
- Contention: m0_req and m1_req rise together, writing 0x11 and 0x22 to 0x8. G0 first; final RAM[2] = 0x22; m1_ack two cycles after m0_ack.
- Lock: m0 sets lock over 3 writes to 0x0, 0x4, 0x8. Acks in 3 consecutive cycles; m1 (requesting) is granted only after lock drops.
- Starvation (guard build, STARVE_LIMIT = 4): m0 continuously requests with lock and m1_req is held high. m1 is granted after exactly 4 m0 acks; without the macro, m1 is never granted while m0 holds lock.
- Peripheral write: m1 writes 0x3 to 0x40000008 (TCON). The memory's TCON reads back 0x3 via m0, and no write is issued in IDLE cycles.
- Reset mid-grant: reset is asserted in a G1 write cycle to 0x0. mem_wr = 0 that cycle, m1_ack = 0, state is IDLE next cycle.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one memory/peripheral port between the CPU data port (m0) and the loader (m1); one access per grant.
// Define ARB_STARVE_GUARD_EN to add the master-1 starvation guard (STARVE_LIMIT consecutive m0 acks).
module mem_bus_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic        m0_lock,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic        m1_lock,
   output logic        m0_gnt,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   output logic        m1_gnt,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, G0, G1} state_t;

   state_t state_q, state_d;
   logic   starve_hit;
   logic   force_rel;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Datapath follows the registered grant only; acks and strobes are suppressed during reset.
   always_comb begin
      m0_gnt    = 1'b0;
      m0_ack    = 1'b0;
      m0_rdata  = '0;
      m1_gnt    = 1'b0;
      m1_ack    = 1'b0;
      m1_rdata  = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      case (state_q)
         G0: begin
            m0_gnt    = 1'b1;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_rd    = m0_req & ~m0_we & ~reset;
            mem_wr    = m0_req &  m0_we & ~reset;
            m0_ack    = m0_req & ~reset;
            m0_rdata  = m0_ack ? mem_rdata : '0;
         end
         G1: begin
            m1_gnt    = 1'b1;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_rd    = m1_req & ~m1_we & ~reset;
            mem_wr    = m1_req &  m1_we & ~reset;
            m1_ack    = m1_req & ~reset;
            m1_rdata  = m1_ack ? mem_rdata : '0;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (m1_req && starve_hit) state_d = G1;
            else if (m0_req)          state_d = G0;
            else if (m1_req)          state_d = G1;
         end
         G0:      state_d = (m0_ack && m0_lock && !force_rel) ? G0 : IDLE;
         G1:      state_d = (m1_ack && m1_lock) ? G1 : IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   logic [7:0] starve_cnt_q, starve_cnt_d;

   assign starve_hit = (starve_cnt_q == LIMIT);

   // The m0 ack that reaches the limit also breaks any m0 lock.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      force_rel    = 1'b0;
      if (m0_ack && m1_req) begin
         if (starve_cnt_q < LIMIT) starve_cnt_d = starve_cnt_q + 8'd1;
         force_rel = (starve_cnt_q >= LIMIT - 8'd1);
      end
      if (state_q == IDLE && !m1_req)        starve_cnt_d = '0;
      if (state_d == G1 && state_q != G1)    starve_cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) starve_cnt_q <= '0;
      else       starve_cnt_q <= starve_cnt_d;
   end
`else
   localparam int unsigned unused_starve_limit = STARVE_LIMIT;

   assign starve_hit = 1'b0;
   assign force_rel  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small RAM/timer/TCON memory model on the shared port.
module tb_mem_bus_arbiter;

   logic        clk;
   logic        reset;
   logic        m0_req, m0_we, m0_lock;
   logic [31:0] m0_addr, m0_wdata;
   logic        m1_req, m1_we, m1_lock;
   logic [31:0] m1_addr, m1_wdata;
   logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_rd, mem_wr, busy;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] ram [0:511];
   logic [31:0] tl = 32'd0;
   logic [31:0] tcon = 32'd0;

   mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
      .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      tl <= tl + 32'd1;
      if (mem_wr) begin
         if (mem_addr[31:28] == 4'h4) begin
            if (mem_addr[7:0] == 8'h08) tcon <= mem_wdata;
         end else begin
            ram[mem_addr[10:2]] <= mem_wdata;
         end
      end
   end

   always_comb begin
      mem_rdata = 32'd0;
      if (mem_addr[31:28] == 4'h4) begin
         if (mem_addr[7:0] == 8'h04)      mem_rdata = tl;
         else if (mem_addr[7:0] == 8'h08) mem_rdata = tcon;
      end else begin
         mem_rdata = ram[mem_addr[10:2]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are changed here, checks follow a #1 settle.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic m0_set(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic lock);
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_lock = lock;
   endtask

   task automatic m1_set(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic lock);
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
   endtask

   initial begin
      reset = 1'b1;
      m0_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      m1_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

      // Reset state
      cyc(); cyc(); #1;
      chk("rst_ctl", {25'd0, m0_gnt, m1_gnt, m0_ack, m1_ack, mem_rd, mem_wr, busy}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
      cyc(); reset = 1'b0;

      // Single write then read by m0
      cyc(); m0_set(1'b1, 1'b1, 32'h4, 32'hDEADBEEF, 1'b0); #1;
      chk("wr_idle_busy", {30'd0, busy, mem_wr}, 32'd0);
      cyc(); #1;
      chk("wr_gnt_ack", {29'd0, m0_gnt, m0_ack, mem_wr}, 32'd7);
      chk("wr_addr", mem_addr, 32'h4);
      chk("wr_data", mem_wdata, 32'hDEADBEEF);
      chk("wr_m1_gnt", {31'd0, m1_gnt}, 32'd0);
      cyc(); m0_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); #1;
      chk("wr_back_idle", {30'd0, busy, m0_gnt}, 32'd0);
      m0_set(1'b1, 1'b0, 32'h4, 32'd0, 1'b0);
      cyc(); #1;
      chk("rd_ack_rd", {30'd0, m0_ack, mem_rd}, 32'd3);
      chk("rd_data", m0_rdata, 32'hDEADBEEF);
      chk("rd_m1_rdata", m1_rdata, 32'd0);
      cyc(); m0_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

      // Contention: both write 0x8, m0 first, m1 two cycles later
      cyc(); m0_set(1'b1, 1'b1, 32'h8, 32'h11, 1'b0); m1_set(1'b1, 1'b1, 32'h8, 32'h22, 1'b0);
      cyc(); #1;
      chk("cont_g0", {28'd0, m0_gnt, m0_ack, m1_gnt, m1_ack}, 32'hC);
      chk("cont_wd0", mem_wdata, 32'h11);
      cyc(); m0_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); #1;
      chk("cont_idle", {30'd0, busy, m1_ack}, 32'd0);
      cyc(); #1;
      chk("cont_g1", {28'd0, m0_gnt, m0_ack, m1_gnt, m1_ack}, 32'h3);
      chk("cont_wd1", mem_wdata, 32'h22);
      cyc(); m1_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      cyc(); m0_set(1'b1, 1'b0, 32'h8, 32'd0, 1'b0);
      cyc(); #1;
      chk("cont_ram2", m0_rdata, 32'h22);
      cyc(); m0_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

      // Locked burst of three writes while m1 waits
      cyc(); m0_set(1'b1, 1'b1, 32'h0, 32'hA0, 1'b1); m1_set(1'b1, 1'b0, 32'h0, 32'd0, 1'b0);
      cyc(); #1;
      chk("lock_ack0", {30'd0, m0_ack, m1_gnt}, 32'd2);
      chk("lock_addr0", mem_addr, 32'h0);
      cyc(); m0_set(1'b1, 1'b1, 32'h4, 32'hA1, 1'b1); #1;
      chk("lock_ack1", {30'd0, m0_ack, m1_gnt}, 32'd2);
      chk("lock_addr1", mem_addr, 32'h4);
      cyc(); m0_set(1'b1, 1'b1, 32'h8, 32'hA2, 1'b0); #1;
      chk("lock_ack2", {30'd0, m0_ack, m1_gnt}, 32'd2);
      chk("lock_addr2", mem_addr, 32'h8);
      cyc(); m0_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); #1;
      chk("lock_idle", {30'd0, busy, m1_gnt}, 32'd0);
      cyc(); #1;
      chk("lock_m1", {30'd0, m1_gnt, m1_ack}, 32'd3);
      chk("lock_m1_rdata", m1_rdata, 32'hA0);
      cyc(); m1_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

      // Starvation: m0 locked and always requesting, m1 waiting
      cyc(); m0_set(1'b1, 1'b1, 32'h10, 32'h5A, 1'b1); m1_set(1'b1, 1'b0, 32'h0, 32'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(); #1;
         chk("starve_m0_ack", {30'd0, m0_ack, m1_gnt}, 32'd2);
      end
`ifdef ARB_STARVE_GUARD_EN
      cyc(); #1;
      chk("starve_release", {30'd0, busy, m0_gnt}, 32'd0);
      cyc(); #1;
      chk("starve_m1", {29'd0, m0_gnt, m1_gnt, m1_ack}, 32'd3);
      chk("starve_m1_rdata", m1_rdata, 32'hA0);
      cyc(); m0_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); m1_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
`else
      for (int i = 0; i < 4; i++) begin
         cyc(); #1;
         chk("nostarve_m0_ack", {30'd0, m0_ack, m1_gnt}, 32'd2);
      end
      cyc(); m0_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); #1;
      chk("withdraw_noack", {29'd0, m0_gnt, m0_ack, mem_wr}, 32'd4);
      cyc(); #1;
      chk("withdraw_idle", {31'd0, busy}, 32'd0);
      cyc(); #1;
      chk("nostarve_m1", {30'd0, m1_gnt, m1_ack}, 32'd3);
      cyc(); m1_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
`endif
      cyc();

      // Peripheral write by m1 to TCON, read back and live timer via m0
      cyc(); m1_set(1'b1, 1'b1, 32'h40000008, 32'h3, 1'b0); #1;
      chk("tcon_idle_nowr", {31'd0, mem_wr}, 32'd0);
      cyc(); #1;
      chk("tcon_wr", {30'd0, m1_ack, mem_wr}, 32'd3);
      chk("tcon_addr", mem_addr, 32'h40000008);
      cyc(); m1_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); #1;
      chk("tcon_after_nowr", {31'd0, mem_wr}, 32'd0);
      m0_set(1'b1, 1'b0, 32'h40000008, 32'd0, 1'b0);
      cyc(); #1;
      chk("tcon_rd", m0_rdata, 32'h3);
      cyc(); m0_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      cyc(); m0_set(1'b1, 1'b0, 32'h40000004, 32'd0, 1'b0);
      cyc(); #1;
      chk("tl_live", m0_rdata, tl);
      cyc(); m0_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

      // Reset asserted during a G1 write
      cyc(); m1_set(1'b1, 1'b1, 32'h0, 32'h55, 1'b0);
      cyc(); reset = 1'b1; #1;
      chk("rstmid_nowr", {30'd0, mem_wr, m1_ack}, 32'd0);
      chk("rstmid_rdata", m1_rdata, 32'd0);
      cyc(); reset = 1'b0; m1_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); #1;
      chk("rstmid_idle", {30'd0, busy, m1_gnt}, 32'd0);
      cyc(); m0_set(1'b1, 1'b0, 32'h0, 32'd0, 1'b0);
      cyc(); #1;
      chk("rstmid_ram0", m0_rdata, 32'hA0);
      cyc(); m0_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
